// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit (mult, multu, div, divu) holding the HI/LO results.
// Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix cycle.
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | waiting for start   RUN | one bit per cycle   FIX | sign fix, write HI/LO   DONE | done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_LOAD = CW'(ITER);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          neg_q;
  logic          neg_r;
  logic          zero_flag;
  logic [31:0]   a_lat;
  logic [31:0]   opnd;
  logic [63:0]   work;

  logic          signed_op;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [32:0]   sum33;
  logic [63:0]   mul_next;
  logic [32:0]   rem33;
  logic          fits;
  logic [63:0]   div_next;
  logic [63:0]   prod_fix;
  logic [31:0]   quot_fix;
  logic [31:0]   rem_fix;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a_in[31];
    b_neg     = signed_op & b_in[31];
    a_mag     = a_neg ? -a_in : a_in;
    b_mag     = b_neg ? -b_in : b_in;

    // multiply: work = {acc, multiplier}, multiplicand in opnd
    sum33    = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {sum33, work[31:1]};

    // divide: work = {rem, quot}; rem needs 33 bits after the shift
    rem33    = {work[63:32], work[31]};
    fits     = rem33 >= {1'b0, opnd};
    div_next = fits ? {rem33[31:0] - opnd, work[30:0], 1'b1}
                    : {rem33[31:0], work[30:0], 1'b0};

    prod_fix = neg_q ? -work : work;
    quot_fix = neg_q ? -work[31:0] : work[31:0];
    rem_fix  = neg_r ? -work[63:32] : work[63:32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_flag <= 1'b0;
      a_lat     <= '0;
      opnd      <= '0;
      work      <= '0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            a_lat    <= a_in;
            opnd     <= b_mag;
            work     <= {32'd0, a_mag};
            cnt      <= ITER_LOAD;
            div_zero <= 1'b0;
            if (op[1] && (b_in == 32'd0)) begin
              zero_flag <= 1'b1;
              state     <= S_FIX;
            end else begin
              zero_flag <= 1'b0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          work <= is_div ? div_next : mul_next;
          cnt  <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (zero_flag) begin
            hi       <= a_lat;
            lo       <= 32'hFFFF_FFFF;
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit, plus hand sequences for
// start-while-busy and mid-operation reset.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int applied    = 0;
  int miscompares = 0;

  mult_div_unit #(.ITER(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!done) $display("FAIL timeout: no done within %0d edges", n);
  endtask

  // Called #1 after a rising edge with the unit idle.
  task automatic run_op(input string tag, input vec_t v);
    int n;
    op = v.op; a_in = v.a; b_in = v.b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    a_in  = ~v.a;
    b_in  = v.b ^ 32'h5A5A_0F0F;
    op    = ~v.op;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, " latency"}, 32'(n), 32'(v.lat));
    check({tag, " hi"}, hi, v.hi);
    check({tag, " lo"}, lo, v.lo);
    check({tag, " div_zero"}, 32'(div_zero), 32'(v.dz));
    @(posedge clock); #1;
    check({tag, " done_width"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int n;
    int done_seen;

    vecs[0]  = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[2]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[6]  = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[7]  = '{OP_MULT,  32'd3,         32'd3,         32'd0,         32'd9,         1'b0, 34};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0, 34};
    vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
    vecs[11] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34};
    vecs[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 34};
    vecs[13] = '{OP_DIV,   32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[14] = '{OP_DIVU,  32'd5,         32'd10,        32'd5,         32'd0,         1'b0, 34};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);

    for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // start pulsed mid-multiply must be ignored
    op = OP_MULT; a_in = 32'h0000_1000; b_in = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(posedge clock); #1; n++; end
    op = OP_DIVU; a_in = 32'd5; b_in = 32'd0; start = 1'b1;
    @(posedge clock); #1;
    n++;
    start = 1'b0;
    while (!done && n < 100) begin @(posedge clock); #1; n++; end
    check("restart latency", 32'(n), 32'd34);
    check("restart hi", hi, 32'd0);
    check("restart lo", lo, 32'h0000_3000);
    check("restart div_zero", 32'(div_zero), 32'd0);
    @(posedge clock); #1;
    check("restart done_width", 32'(done), 32'd0);

    // reset in the middle of a divide abandons it
    op = OP_DIVU; a_in = 32'd1000; b_in = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("midreset no_done", 32'(done_seen), 32'd0);
    run_op("after_reset", '{OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 34});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle MIPS datapath.
- Implements mult, multu, div and divu on operands taken from the A and B registers.
- Holds the architectural HI/LO results. The write-back mux reads these for mfhi/mflo.
- The control unit drives it with a start/done handshake and holds its state machine in a wait state while busy is high.

Parameters:
- ITER, 32, number of iteration cycles; must equal the operand width (32).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu
- a_in  input  32  operand rs (A register output); dividend for div
- b_in  input  32  operand rt (B register output); divisor for div
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; HI/LO are valid and updated in this cycle
- div_zero  output  1  sticky flag: last div/divu had divisor 0; cleared on next accepted start
- hi  output  32  mult: product[63:32]; div: remainder
- lo  output  32  mult: product[31:0]; div: quotient

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - hi, lo and all internal registers are cleared to 0.
  - busy, done and div_zero are cleared to 0.
  - An operation in flight is abandoned; no done pulse follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On start=1, latch op, a_in and b_in, clear div_zero, load the iteration counter with ITER, go to RUN.
  - Signed ops convert operands to magnitudes and record the result signs:
    - product sign = sign(a) XOR sign(b)
    - quotient sign = sign(a) XOR sign(b)
    - remainder sign = sign(a)
  - div/divu with b_in=0: go directly to FIX and set the zero flag internally.
- RUN: one iteration per cycle; counter decrements; go to FIX when the counter reaches 0.
  - Multiply: shift-add on 64-bit {acc, multiplier}. If the multiplier LSB is 1, add the multiplicand to acc with a 33-bit carry, then shift right 1.
  - Divide: restoring division on 64-bit {rem, quot}. Shift left 1, trial-subtract the divisor from rem. If non-negative, keep the difference and set quot LSB to 1; otherwise restore.
- FIX (1 cycle):
  - Apply sign correction with 64-bit negation for the product and 32-bit negation for the quotient/remainder.
  - Write hi/lo, go to DONE.
  - Divide by zero: hi=a_in as latched, lo=0xFFFFFFFF, div_zero=1.
- DONE (1 cycle): done=1, busy=0, go to IDLE.
- busy=1 in RUN and FIX, and in the cycle after start is accepted.
- Latency, counting the start edge as edge 0:
  - done is high after edge ITER+2, i.e. 34 cycles for normal operations.
  - done is high after edge 2 for divide by zero.
- Next start: accepted in IDLE, which is the cycle after done.
- start while busy or in DONE: ignored; the operation in progress is unaffected and no request is queued.
- Signed semantics:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (div): lo=0x80000000, hi=0; no trap, no flag.
- hi/lo hold their values between completions. Only FIX writes them.
- The latched op and operands are stable for the whole operation; changes on a_in/b_in after start have no effect.

Test Plan:
- Reset, then idle for 5 cycles -> hi=lo=0, busy=0, done=0, div_zero=0.
- mult a=7, b=0xFFFFFFFD (-3) -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. mult of the same operands -> hi=0, lo=1.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100, b=7 -> lo=14, hi=2.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=0x1234, b=0 -> done 2 cycles after start; hi=0x1234, lo=0xFFFFFFFF, div_zero=1.
  - A following mult 3*3 clears div_zero and gives lo=9.
- Robustness:
  - Pulse start again at cycle 10 of a mult with different operands -> ignored; the original result is produced.
  - Assert reset at cycle 15 of a div -> immediately busy=0, hi=lo=0; no done pulse; the next start works normally.
